oreg_bank_arb: RTL and testbench

Arbiter and sequencer for a bank of clock-enabled output registers (SP/CD-style I/O flops). It shares one WIDTH-bit output register bank between two requesters, transfers bursts of words into the bank, and drives the bank's D, clock-enable (SP) and clear (CD) inputs. It sits between core-side producers and the pad-side output register primitives, all clocked on SCLK.

---
 rtl/oreg_bank_arb.sv | 131 +++++++++++++
 tb/tb_oreg_bank_arb.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/oreg_bank_arb.sv
// oreg_bank_arb: shares one clock-enabled output register bank (D/SP/CD)
// between two requesters, sequencing bursts of LEN+1 words into it.
// Ties are broken round-robin; a requester that drops REQ mid-burst
// causes a one-cycle clear pulse on the bank.
module oreg_bank_arb #(
    parameter int WIDTH = 8,
    parameter int LENW  = 4
) (
    input  logic             SCLK,
    input  logic             RSTN,
    input  logic             REQ0,
    input  logic [LENW-1:0]  LEN0,
    input  logic [WIDTH-1:0] DAT0,
    input  logic             REQ1,
    input  logic [LENW-1:0]  LEN1,
    input  logic [WIDTH-1:0] DAT1,
    output logic             GNT0,
    output logic             GNT1,
    output logic             ACK0,
    output logic             ACK1,
    output logic [WIDTH-1:0] OD,
    output logic             OSP,
    output logic             OCD,
    output logic             BUSY
);

    typedef enum logic [1:0] {IDLE, XFER, GAP, ABORT} state_t;

    state_t           state, state_nx;
    logic             pri, pri_nx;
    logic             sel, sel_nx;
    logic [LENW-1:0]  cnt, cnt_nx;
    logic [WIDTH-1:0] od_nx;
    logic             osp_nx, ocd_nx, gnt0_nx, gnt1_nx;

    logic             req_sel;
    logic [WIDTH-1:0] dat_sel;
    logic             win;

    // Owner's request/data, and the IDLE arbitration winner
    // (sole requester, otherwise the priority holder).
    assign req_sel = sel ? REQ1 : REQ0;
    assign dat_sel = sel ? DAT1 : DAT0;
    assign win     = (REQ0 && REQ1) ? pri : REQ1;

    // A word is taken whenever the owner keeps requesting in XFER.
    assign ACK0 = (state == XFER) && !sel && REQ0;
    assign ACK1 = (state == XFER) &&  sel && REQ1;
    assign BUSY = (state != IDLE);

    // Next-state and next-output logic; SP and CD default low so they
    // only pulse for the single cycle that asks for them.
    always_comb begin
        state_nx = state;
        pri_nx   = pri;
        sel_nx   = sel;
        cnt_nx   = cnt;
        od_nx    = OD;
        osp_nx   = 1'b0;
        ocd_nx   = 1'b0;
        gnt0_nx  = GNT0;
        gnt1_nx  = GNT1;
        case (state)
            IDLE: begin
                gnt0_nx = 1'b0;
                gnt1_nx = 1'b0;
                if (REQ0 || REQ1) begin
                    sel_nx   = win;
                    cnt_nx   = win ? LEN1 : LEN0;
                    gnt0_nx  = !win;
                    gnt1_nx  = win;
                    state_nx = XFER;
                end
            end
            XFER: begin
                if (req_sel) begin
                    od_nx  = dat_sel;
                    osp_nx = 1'b1;
                    if (cnt == '0) begin
                        gnt0_nx  = 1'b0;
                        gnt1_nx  = 1'b0;
                        state_nx = GAP;
                    end else begin
                        cnt_nx = cnt - LENW'(1);
                    end
                end else begin
                    // owner walked away: clear the partially written bank
                    ocd_nx   = 1'b1;
                    gnt0_nx  = 1'b0;
                    gnt1_nx  = 1'b0;
                    state_nx = ABORT;
                end
            end
            GAP: begin
                pri_nx   = ~sel;
                state_nx = IDLE;
            end
            ABORT: begin
                pri_nx   = ~sel;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and registered bank outputs; reset aborts without a CD pulse.
    always_ff @(posedge SCLK) begin
        if (!RSTN) begin
            state <= IDLE;
            pri   <= 1'b0;
            sel   <= 1'b0;
            cnt   <= '0;
            OD    <= '0;
            OSP   <= 1'b0;
            OCD   <= 1'b0;
            GNT0  <= 1'b0;
            GNT1  <= 1'b0;
        end else begin
            state <= state_nx;
            pri   <= pri_nx;
            sel   <= sel_nx;
            cnt   <= cnt_nx;
            OD    <= od_nx;
            OSP   <= osp_nx;
            OCD   <= ocd_nx;
            GNT0  <= gnt0_nx;
            GNT1  <= gnt1_nx;
        end
    end

endmodule

// File: tb/tb_oreg_bank_arb.sv
// Directed bench for oreg_bank_arb: words expected on OD are queued as
// stimulus is issued and checked by a monitor whenever OSP is high.
module tb_oreg_bank_arb;
    localparam int W  = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          req0, req1;
    logic [LW-1:0] len0, len1;
    logic [W-1:0]  dat0, dat1;
    logic          gnt0, gnt1, ack0, ack1;
    logic [W-1:0]  od;
    logic          osp, ocd, busy;

    oreg_bank_arb #(.WIDTH(W), .LENW(LW)) dut (
        .SCLK(clk), .RSTN(rstn),
        .REQ0(req0), .LEN0(len0), .DAT0(dat0),
        .REQ1(req1), .LEN1(len1), .DAT1(dat1),
        .GNT0(gnt0), .GNT1(gnt1), .ACK0(ack0), .ACK1(ack1),
        .OD(od), .OSP(osp), .OCD(ocd), .BUSY(busy)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    bit mon_en = 1'b0;
    logic [W-1:0] exp_q[$];
    int osp_cyc[$];
    int order_q[$];
    int n_gnt0 = 0, n_gnt1 = 0, n_ocd = 0, n_ack0 = 0, n_ack1 = 0;
    logic [W-1:0] e_od;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    // monitor: counts activity and checks each word landing in the bank
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (gnt0 === 1'b1) n_gnt0++;
            if (gnt1 === 1'b1) n_gnt1++;
            if (ocd  === 1'b1) n_ocd++;
            if (ack0 === 1'b1) n_ack0++;
            if (ack1 === 1'b1) n_ack1++;
            chk("gnt_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
            if (osp === 1'b1) begin
                osp_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL od_unexpected: got %0h want none", od);
                end else begin
                    e_od = exp_q.pop_front();
                    chk("od", {24'd0, od}, {24'd0, e_od});
                end
            end
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // one requester: n words expected, REQ dropped after n ACKs
    task automatic burst(input bit r, input int len, input int n,
                         input logic [W-1:0] base, input int newlen);
        int i, t;
        logic a;
        for (int k = 0; k < n; k++) exp_q.push_back(base + W'(k));
        i = 0; t = 0;
        if (r) begin len1 = LW'(len); dat1 = base; req1 = 1'b1; end
        else   begin len0 = LW'(len); dat0 = base; req0 = 1'b1; end
        while (i < n && t < 300) begin
            @(negedge clk); a = r ? ack1 : ack0;
            @(posedge clk); #1; t++;
            if (t == 1 && newlen >= 0) begin
                if (r) len1 = LW'(newlen); else len0 = LW'(newlen);
            end
            if (a === 1'b1) begin
                i++;
                if (r) dat1 = base + W'(i); else dat0 = base + W'(i);
            end
        end
        chk("burst_acks", i, n);
        if (r) req1 = 1'b0; else req0 = 1'b0;
    endtask

    // both requesting with LEN=0 until nacks words taken; order recorded
    task automatic tie(input int nacks, input logic [W-1:0] b0, input logic [W-1:0] b1);
        int c, t;
        logic a0, a1;
        c = 0; t = 0;
        order_q.delete();
        len0 = '0; len1 = '0; dat0 = b0; dat1 = b1;
        req0 = 1'b1; req1 = 1'b1;
        while (c < nacks && t < 300) begin
            @(negedge clk); a0 = ack0; a1 = ack1;
            @(posedge clk); #1; t++;
            if (a0 === 1'b1) begin order_q.push_back(0); dat0 = dat0 + 8'd1; c++; end
            if (a1 === 1'b1) begin order_q.push_back(1); dat1 = dat1 + 8'd1; c++; end
        end
        chk("tie_acks", c, nacks);
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_gnt0"}, gnt0, 0);
        chk({name, "_gnt1"}, gnt1, 0);
        chk({name, "_ack"}, {ack1, ack0}, 0);
        chk({name, "_od"}, od, 0);
        chk({name, "_osp"}, osp, 0);
        chk({name, "_ocd"}, ocd, 0);
        chk({name, "_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, g1, a0, a1, oc;
        rstn = 1'b0; req0 = 1'b0; req1 = 1'b0;
        len0 = '0; len1 = '0; dat0 = '0; dat1 = '0;
        step(2);
        rstn = 1'b1; mon_en = 1'b1;
        chk_quiet("reset");

        // warm-up burst from 0 moves priority to 1
        burst(0, 1, 2, 8'h30, -1);
        step(3);

        // reset in the middle of a requester-1 burst
        oc = n_ocd;
        burst(1, 5, 2, 8'h40, -1);
        rstn = 1'b0;
        step(1);
        rstn = 1'b1;
        chk_quiet("midreset");
        step(3);
        chk("midreset_no_ocd", n_ocd - oc, 0);

        // contention: priority reset to 0, strict alternation
        exp_q.push_back(8'h10); exp_q.push_back(8'h20);
        exp_q.push_back(8'h11); exp_q.push_back(8'h21);
        osp_cyc.delete();
        tie(4, 8'h10, 8'h20);
        step(3);
        chk("tie_n", order_q.size(), 4);
        for (int k = 0; k < order_q.size() && k < 4; k++) chk("tie_order", order_q[k], k % 2);
        chk("osp_n", osp_cyc.size(), 4);
        for (int k = 1; k < osp_cyc.size() && k < 4; k++)
            chk("osp_spacing", osp_cyc[k] - osp_cyc[k-1], 3);

        // single 4-word burst
        g0 = n_gnt0; g1 = n_gnt1; a0 = n_ack0;
        burst(0, 3, 4, 8'hA0, -1);
        @(negedge clk);
        chk("single_gap_gnt0", gnt0, 0);
        chk("single_gap_busy", busy, 1);
        step(3);
        chk("single_gnt0_cyc", n_gnt0 - g0, 4);
        chk("single_gnt1_cyc", n_gnt1 - g1, 0);
        chk("single_ack0", n_ack0 - a0, 4);

        // maximum length burst on requester 1
        g1 = n_gnt1; a1 = n_ack1;
        burst(1, 15, 16, 8'hB0, -1);
        step(4);
        chk("max_ack1", n_ack1 - a1, 16);
        chk("max_gnt1_cyc", n_gnt1 - g1, 16);
        chk("max_idle", busy, 0);

        // abort after two words
        oc = n_ocd; g0 = n_gnt0;
        burst(0, 5, 2, 8'hC0, -1);
        step(1);
        chk("abort_ocd", ocd, 1);
        chk("abort_osp", osp, 0);
        chk("abort_gnt0", gnt0, 0);
        chk("abort_busy", busy, 1);
        step(1);
        chk("abort_ocd_end", ocd, 0);
        chk("abort_idle", busy, 0);
        step(2);
        chk("abort_ocd_cyc", n_ocd - oc, 1);
        chk("abort_gnt0_cyc", n_gnt0 - g0, 3);

        // tie after the abort goes to requester 1
        exp_q.push_back(8'h55);
        tie(1, 8'h44, 8'h55);
        step(3);
        chk("post_abort_owner", order_q.size() > 0 ? order_q[0] : -1, 1);

        // LEN change after grant is ignored
        g0 = n_gnt0; oc = n_ocd;
        burst(0, 2, 3, 8'hD0, 7);
        @(negedge clk);
        chk("lenchg_gap_gnt0", gnt0, 0);
        step(3);
        chk("lenchg_gnt0_cyc", n_gnt0 - g0, 3);
        chk("lenchg_no_ocd", n_ocd - oc, 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
